// File: rtl/sc2110_pkg.sv
// SC2110 LVDS link constants shared by the transmit trainer and the receive aligner.
package sc2110_pkg;

  // 4 lanes x 12 bits
  localparam int DATA_W = 48;

  localparam logic [DATA_W-1:0] PAT_A     = 48'h0000_0f00_0000;
  localparam logic [DATA_W-1:0] PAT_B     = 48'h0000_00f0_0000;
  localparam logic [DATA_W-1:0] IDLE_WORD = 48'h0;

  // Link state encoding
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRAIN = 2'd1,
    S_DATA  = 2'd2
  } state_e;

endpackage

// File: rtl/sc2110_pat_gen.sv
// A/B training phase toggle plus saturating training-word counter.
module sc2110_pat_gen #(
  parameter int unsigned TRAIN_MAX = 4096
) (
  input  logic        I_clk,
  input  logic        I_rstn,
  input  logic        I_init,       // restart: phase A, count 0
  input  logic        I_step,       // one training word taken this cycle
  output logic        O_phase_b,    // 1 = word offered now is PAT_B
  output logic [15:0] O_count_inc   // count including the word offered now
);

  localparam logic [15:0] CNT_MAX = 16'(TRAIN_MAX);

  logic        phase_q, phase_d;
  logic [15:0] count_q, count_d;
  logic [15:0] count_inc;

  // Saturating increment, also exported so the trainer can judge the word in flight
  always_comb begin
    count_inc = (count_q >= CNT_MAX) ? CNT_MAX : count_q + 16'd1;
  end

  // Next phase/count: init dominates a step
  always_comb begin
    phase_d = phase_q;
    count_d = count_q;
    if (I_init) begin
      phase_d = 1'b0;
      count_d = 16'd0;
    end else if (I_step) begin
      phase_d = ~phase_q;
      count_d = count_inc;
    end
  end

  // Phase and count registers
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      phase_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  assign O_phase_b   = phase_q;
  assign O_count_inc = count_inc;

endmodule

// File: rtl/sc2110_train_tx.sv
// SC2110 transmit link trainer: idle words, A/B training pattern until far-end lock, then pixel pass-through.
module sc2110_train_tx
  import sc2110_pkg::*;
#(
  parameter int                DATA_W    = sc2110_pkg::DATA_W,
  parameter logic [DATA_W-1:0] PAT_A     = sc2110_pkg::PAT_A,
  parameter logic [DATA_W-1:0] PAT_B     = sc2110_pkg::PAT_B,
  parameter logic [DATA_W-1:0] IDLE_WORD = sc2110_pkg::IDLE_WORD,
  parameter int unsigned       TRAIN_MIN = 256,
  parameter int unsigned       TRAIN_MAX = 4096
) (
  input  logic              I_clk,
  input  logic              I_rstn,
  input  logic              I_en,
  input  logic              I_retrain,
  input  logic              I_lock,
  input  logic              I_tx_ready,
  input  logic              I_pix_valid,
  input  logic [DATA_W-1:0] I_pix_data,
  output logic              O_pix_ready,
  output logic [DATA_W-1:0] O_tx_data,
  output logic              O_tx_valid,
  output logic              O_training,
  output logic              O_link_up,
  output logic              O_train_err
);

  localparam logic [15:0] CNT_MIN = 16'(TRAIN_MIN);
  localparam logic [15:0] CNT_MAX = 16'(TRAIN_MAX);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q;
  logic              err_q, err_d;
  logic              pg_init, pg_step;
  logic              phase_b;
  logic [15:0]       count_inc;

  sc2110_pat_gen #(
    .TRAIN_MAX (TRAIN_MAX)
  ) u_pat_gen (
    .I_clk       (I_clk),
    .I_rstn      (I_rstn),
    .I_init      (pg_init),
    .I_step      (pg_step),
    .O_phase_b   (phase_b),
    .O_count_inc (count_inc)
  );

  // Pixel is consumed only on a serializer slot while the link is up
  assign O_pix_ready = (state_q == S_DATA) && I_tx_ready;

  // Next state, next output word and error flag; transitions in priority order
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    err_d     = err_q;
    pg_init   = 1'b0;
    pg_step   = 1'b0;

    // The word taken on a slot is decided by the current state; between slots the output holds
    if (I_tx_ready) begin
      case (state_q)
        S_TRAIN: tx_data_d = phase_b ? PAT_B : PAT_A;
        S_DATA:  tx_data_d = I_pix_valid ? I_pix_data : IDLE_WORD;
        default: tx_data_d = IDLE_WORD;
      endcase
    end

    if (!I_en) begin
      state_d = S_IDLE;
    end else if (I_retrain || (state_q == S_IDLE)) begin
      state_d = S_TRAIN;
      pg_init = 1'b1;
      err_d   = 1'b0;
    end else if ((state_q == S_TRAIN) && I_tx_ready) begin
      pg_step = 1'b1;
      if ((count_inc >= CNT_MAX) && !I_lock) begin
        err_d = 1'b1;
      end
      // Leave only after a PAT_B so data always follows a complete A/B pair
      if (phase_b && (count_inc >= CNT_MIN) && I_lock) begin
        state_d = S_DATA;
      end
    end
  end

  // State, output word and flag registers
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state_q    <= S_IDLE;
      tx_data_q  <= IDLE_WORD;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= 1'b1;
      err_q      <= err_d;
    end
  end

  assign O_tx_data   = tx_data_q;
  assign O_tx_valid  = tx_valid_q;
  assign O_training  = (state_q == S_TRAIN);
  assign O_link_up   = (state_q == S_DATA);
  assign O_train_err = err_q;

endmodule

// File: doc/sc2110_train_tx.md
# sc2110_train_tx

Transmit-side link trainer for the SC2110 4-lane × 12-bit LVDS parallel word path. It produces the 48-bit words that the output serializer consumes:
- idle words while disabled;
- the alternating training pair 0x0000_0f00_0000 / 0x0000_00f0_0000 until the far-end bitslip aligner reports lock;
- pixel pass-through after lock.

It is the source end of the bitslip alignment used on the receive path. It drives sensor-model benches and the loopback self-test.

## Interface
Parameters:
- DATA_W, 48, parallel word width (4 lanes × 12 bits)
- PAT_A, 48'h0000_0f00_0000, first training word
- PAT_B, 48'h0000_00f0_0000, second training word
- IDLE_WORD, 48'h0, word sent when idle or when no pixel is available
- TRAIN_MIN, 256, minimum training words before data may start (even, ≥2)
- TRAIN_MAX, 4096, training words without lock before error is flagged (> TRAIN_MIN)

Ports:
- I_clk  in  1  clock
- I_rstn  in  1  reset: I_rstn, asynchronous, active-low
- I_en  in  1  level; 1 = link enabled
- I_retrain  in  1  single-cycle request to restart training
- I_lock  in  1  far-end alignment done, already synchronous to I_clk
- I_tx_ready  in  1  serializer slot strobe; word taken on every cycle it is high
- I_pix_valid  in  1  pixel word available
- I_pix_data  in  DATA_W  pixel word
- O_pix_ready  out  1  pixel word accepted this cycle
- O_tx_data  out  DATA_W  registered word to serializer
- O_tx_valid  out  1  O_tx_data meaningful
- O_training  out  1  state is S_TRAIN
- O_link_up  out  1  state is S_DATA
- O_train_err  out  1  sticky: TRAIN_MAX training words sent without lock

## Operation
- States:
  - S_IDLE: emit IDLE_WORD.
  - S_TRAIN: emit PAT_A, PAT_B, PAT_A, … advancing one word per I_tx_ready.
  - S_DATA: emit pixel words, or IDLE_WORD on a slot with I_pix_valid=0.
- Transitions, evaluated every cycle, priority top-down:
  - I_en=0 → S_IDLE from any state.
  - I_retrain=1 with I_en=1 → S_TRAIN. Word count cleared, phase reset to A, O_train_err cleared.
  - S_IDLE with I_en=1 → S_TRAIN, same initialisation.
  - S_TRAIN → S_DATA only on a slot (I_tx_ready=1) where all of the following hold: the word being taken is PAT_B, count ≥ TRAIN_MIN, and I_lock=1. Data therefore always follows a complete A/B pair.
  - S_DATA stays until I_en=0 or I_retrain. Loss of I_lock in S_DATA is ignored.
- Word count:
  - 16-bit; increments on each training slot; saturates at TRAIN_MAX.
  - When count reaches TRAIN_MAX with I_lock=0: O_train_err sets. Training continues, and still exits normally if lock arrives later.
- O_pix_ready = (state==S_DATA) && I_tx_ready, combinational. A pixel transfers when I_pix_valid && O_pix_ready. No buffering; pixels offered outside S_DATA are not consumed.
- The output register loads the next word at the edge ending each I_tx_ready cycle. Between strobes it holds.

## Timing
- Reset values:
  - O_tx_data=IDLE_WORD, O_tx_valid=0.
  - O_training=0, O_link_up=0, O_train_err=0.
  - State S_IDLE, count 0, phase A.
- O_tx_valid rises on the first clock after reset release and stays 1.
- The first training word is loaded at the first I_tx_ready cycle after S_TRAIN is entered. Output latency is 1 clock from the slot decision to O_tx_data.
- The first pixel appears on O_tx_data 1 clock after the transfer cycle. That transfer cycle is the slot immediately after the PAT_B slot that met the exit condition.
- I_en=0 or I_retrain mid-word: state changes at the next edge. O_tx_data is updated only at the next I_tx_ready, never mid-slot.
- I_retrain and the exit condition in the same cycle: retrain wins.
- O_training, O_link_up and O_train_err are registered and decoded from the state/flag registers.

## Structure
- Shared package sc2110_pkg: DATA_W, PAT_A, PAT_B, IDLE_WORD, and the state encoding constants. These are shared with the receive-side aligner.
- Single module. An optional sub-module sc2110_pat_gen can hold the A/B phase toggle and the saturating word counter.

## Test plan
- Enable with I_lock tied 1, TRAIN_MIN=8 → exactly 8 words alternating 0x0000_0f00_0000 / 0x0000_00f0_0000, last word PAT_B, then first pixel 0x123456789ABC with O_link_up=1.
- Lock asserted while count=3 → training continues to count 8. Lock asserted during a PAT_A slot at count ≥ TRAIN_MIN → one more PAT_B is sent before data.
- I_lock=0, TRAIN_MAX=32 → O_train_err=1 after 32 training slots. Lock then raised → link comes up and the error stays set until I_retrain.
- In S_DATA with I_tx_ready toggling every 3rd cycle and I_pix_valid gaps → every accepted pixel is output once, in order. Gap slots carry IDLE_WORD; O_pix_ready is never high without I_tx_ready.
- I_retrain in S_DATA → next word PAT_A, count restarts, O_link_up falls 1 clock later.
- I_en dropped mid-training, and I_rstn pulsed mid-data → IDLE_WORD at next slot. After reset, all outputs are at their reset values and O_tx_valid=0 for one cycle.
